reg_file_param: RTL
===================

// Module: reg_file_param
// PURPOSE
//  Parametrised 2-read/1-write register file, the successor to the fixed 32x32 array.
//  Sits in the decode stage of the datapath.
//  Adds: configurable width/depth, optional hardwired zero register, write-to-read bypass,
//  synchronous reset with an FSM-driven hardware clear sweep, and a dropped-write flag.
//  Clear takes DEPTH cycles after reset release; busy gates the pipeline during that time.
// PARAMETERS
//  DATA_W    32  data width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
//  BYPASS    1   1: same-cycle write data is forwarded to a matching read; 0: no forwarding
// PORTS
//  clk       in   1       clock; all state updates on posedge
//  rst       in   1       synchronous, active-high reset
//  rd_addr1  in   ADDR_W  read port 1 address
//  rd_addr2  in   ADDR_W  read port 2 address
//  rd_data1  out  DATA_W  read port 1 data (combinational)
//  rd_data2  out  DATA_W  read port 2 data (combinational)
//  wr_en     in   1       write enable (single bit; only 1'b1 writes)
//  wr_addr   in   ADDR_W  write address
//  wr_data   in   DATA_W  write data
//  busy      out  1       1 while the clear sweep runs; writes are dropped
//  wr_drop   out  1       registered pulse: a write was attempted while busy
// BEHAVIOUR
//  FSM states: CLEAR, RUN. Counter clr_idx is ADDR_W bits wide.
//  - rst=1 at a posedge: state<=CLEAR, clr_idx<=0, wr_drop<=0. Array contents are not touched.
//  - CLEAR with rst=0: RF[clr_idx]<=0 and clr_idx<=clr_idx+1.
//    When clr_idx==DEPTH-1 is written: state<=RUN, clr_idx wraps to 0.
//  - Result: exactly DEPTH cycles of busy=1 after rst deasserts.
//  - RUN: wr_en=1 writes RF[wr_addr]<=wr_data. Exception: when ZERO_REG=1 and wr_addr==0, no write.
//  - Reset values: busy=1 (busy = state==CLEAR, combinational), wr_drop=0.
//  - Reads are combinational, 0-cycle latency.
//    Priority per port, highest first:
//     1. state==CLEAR -> 0.
//     2. ZERO_REG=1 and rd_addr==0 -> 0.
//     3. BYPASS=1, wr_en=1, wr_addr==rd_addr -> wr_data.
//     4. Otherwise RF[rd_addr].
//  - Write in CLEAR: dropped, never queued. wr_drop<=1 on the next edge, else wr_drop<=0.
//  - rst asserted mid-sweep: sweep restarts from index 0; full DEPTH cycles follow release.
//  - Simultaneous write and read of the same address with BYPASS=0: read returns the old value.
//    The new value is visible from the cycle after the edge.
//  - Both read ports may hit the same address, and the write address, in the same cycle.
//  - Multi-bit RegWrite encoding is retired; wr_en is 1 bit.
// TESTING
//  T1 reset/clear: assert rst 3 cycles, release -> busy=1 for exactly 32 cycles.
//     Every entry then reads 0, and busy=0 from cycle 33.
//  T2 write/read: RUN, write 0xDEADBEEF to r5 -> rd_data1 shows 0xDEADBEEF combinationally (bypass).
//     It still reads 0xDEADBEEF after the edge; r6 is unchanged (0).
//  T3 zero reg: write 0x12345678 to r0 -> rd_addr1=0 returns 0 in the same and the next cycle.
//     With ZERO_REG=0 the same sequence returns 0x12345678.
//  T4 bypass off: BYPASS=0, r7=0x1, write 0x2 to r7 while reading r7 on both ports -> both show 0x1.
//     Both show 0x2 on the next cycle.
//  T5 mid-sweep reset: pulse rst at clear cycle 10 -> busy stays 1 for 32 more cycles after release.
//     Writes attempted during the sweep set wr_drop=1 one cycle later and leave the target at 0.
//  T6 param sweep: DATA_W=16, ADDR_W=3 -> clear lasts 8 cycles.
//     Write 0xFFFF to r7 wraps no index; reading r7 returns 0xFFFF.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file for the decode stage.
// After reset a hardware sweep zeroes every entry over DEPTH cycles while busy is high.
module reg_file_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wr_drop
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] rf [DEPTH];
    logic              wr_commit;

    // Writes land only in RUN; entry 0 is read-only when hardwired to zero.
    assign wr_commit = (state == RUN) && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave CLEAR once the last entry is being zeroed.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Output logic: busy is a pure decode of the state.
    always_comb begin
        busy = 1'b0;
        if (state == CLEAR) busy = 1'b1;
    end

    // Sweep index: advances every CLEAR cycle and wraps back to 0 on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + ADDR_W'(1);
        end
    end

    // Dropped-write flag: one-cycle pulse for each write attempted during the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= (state == CLEAR) && wr_en;
        end
    end

    // Storage: the sweep owns the array in CLEAR; reset itself leaves contents alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                rf[clr_idx] <= '0;
            end else if (wr_commit) begin
                rf[wr_addr] <= wr_data;
            end
        end
    end

    // Read port 1: clear, zero register, bypass, then array.
    always_comb begin
        rd_data1 = rf[rd_addr1];
        if (state == CLEAR) begin
            rd_data1 = '0;
        end else if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd_data2 = rf[rd_addr2];
        if (state == CLEAR) begin
            rd_data2 = '0;
        end else if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
    end

endmodule
